// File: rtl/io_mmio_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : io_mmio_ctrl
// Description : Memory-mapped CPU <-> board I/O controller. Debounced buttons,
//               a switch-sample FIFO filled by buttonR, and a staged LED value
//               committed to the pins by buttonL.
//               Optional build macro: IO_IRQ_EN (adds a registered irq output
//               = fifo_nempty | led_done).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module io_mmio_ctrl #(
   parameter int SW_W     = 16,
   parameter int LED_W    = 12,
   parameter int FIFO_DEP = 4,
   parameter int DEB_CYC  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pRead,
   input  logic              pWrite,
   input  logic [1:0]        addr,
   input  logic [31:0]       pWriteData,
   output logic [31:0]       pReadData,
   input  logic              buttonL,
   input  logic              buttonR,
   input  logic [SW_W-1:0]   switch,
`ifdef IO_IRQ_EN
   output logic [LED_W-1:0]  led,
   output logic              irq
`else
   output logic [LED_W-1:0]  led
`endif
);

   localparam int AW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
   localparam int CW = $clog2(FIFO_DEP + 1);
   localparam int DW = $clog2(DEB_CYC + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEP);

   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_SWDATA = 2'd1;
   localparam logic [1:0] A_LEDSTG = 2'd2;
   localparam logic [1:0] A_CTRL   = 2'd3;

   // Button index 0 = buttonL (commit), 1 = buttonR (capture)
   logic [1:0]      btn_s1_q, btn_s2_q;
   logic [SW_W-1:0] sw_s1_q, sw_s2_q;
   logic [1:0]      deb_lvl_q, deb_prev_q;
   logic [DW-1:0]   deb_cnt_q [2];
   logic [1:0]      press;

   logic [SW_W-1:0] fifo_mem_q [FIFO_DEP];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

   logic [LED_W-1:0] stg_q, led_q;
   logic             pending_q, ovf_q, done_q;

   logic fifo_nempty, fifo_full;
   logic pop, push, ovf_set, flush;
   logic stage_wr, commit, clr_ovf, clr_done;
   logic unused_wdata;

   // Upper write-data bits beyond the LED width carry no meaning here
   assign unused_wdata = &{1'b0, pWriteData};

   // Two-flop synchronisers for the asynchronous board inputs
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= {buttonR, buttonL};
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= switch;
         sw_s2_q  <= sw_s1_q;
      end
   end

   // Debounce: level flips after DEB_CYC consecutive cycles of disagreement
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_lvl_q  <= '0;
         deb_prev_q <= '0;
         deb_cnt_q  <= '{default: '0};
      end else begin
         deb_prev_q <= deb_lvl_q;
         for (int b = 0; b < 2; b++) begin
            if (btn_s2_q[b] != deb_lvl_q[b]) begin
               if (deb_cnt_q[b] == DEB_MAX) begin
                  deb_lvl_q[b] <= ~deb_lvl_q[b];
                  deb_cnt_q[b] <= '0;
               end else begin
                  deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
               end
            end else begin
               deb_cnt_q[b] <= '0;
            end
         end
      end
   end

   // One-cycle pulse on the rising edge of each debounced level
   assign press = deb_lvl_q & ~deb_prev_q;

   assign fifo_nempty = (fifo_cnt_q != '0);
   assign fifo_full   = (fifo_cnt_q == CNT_FULL);

   assign pop      = pRead  && (addr == A_SWDATA) && fifo_nempty;
   assign flush    = pWrite && (addr == A_CTRL) && pWriteData[2];
   assign clr_ovf  = pWrite && (addr == A_CTRL) && pWriteData[0];
   assign clr_done = pWrite && (addr == A_CTRL) && pWriteData[1];
   assign stage_wr = pWrite && (addr == A_LEDSTG);
   // A pop in the same cycle frees the slot the push needs
   assign push     = press[1] && (!fifo_full || pop);
   assign ovf_set  = press[1] && fifo_full && !pop;
   assign commit   = press[0] && pending_q;

   assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

   // FIFO pointers and occupancy; flush overrides any concurrent push/pop
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

   // Sample storage; no reset needed since reads are gated by occupancy
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= sw_s2_q;
   end

   // LED staging/commit and sticky status flags (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         stg_q     <= '0;
         led_q     <= '0;
         pending_q <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (stage_wr) stg_q <= pWriteData[LED_W-1:0];
         if (commit)   led_q <= stg_q;

         if (stage_wr)    pending_q <= 1'b1;
         else if (commit) pending_q <= 1'b0;

         if (ovf_set)      ovf_q <= 1'b1;
         else if (clr_ovf) ovf_q <= 1'b0;

         if (commit)        done_q <= 1'b1;
         else if (clr_done) done_q <= 1'b0;
      end
   end

   assign led = led_q;

`ifdef IO_IRQ_EN
   // Interrupt follows the flags one cycle later
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= fifo_nempty | done_q;
   end
`endif

   // Read mux from pre-edge state
   always_comb begin
      pReadData = '0;
      case (addr)
         A_STATUS: begin
            pReadData[0]    = fifo_nempty;
            pReadData[1]    = fifo_full;
            pReadData[2]    = pending_q;
            pReadData[3]    = ovf_q;
            pReadData[4]    = done_q;
            pReadData[15:8] = 8'(fifo_cnt_q);
         end
         A_SWDATA: begin
            if (fifo_nempty) pReadData[SW_W-1:0] = fifo_mem_q[rd_ptr_q];
         end
         A_LEDSTG: pReadData[LED_W-1:0] = stg_q;
         default:  pReadData = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_io_mmio_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_io_mmio_ctrl
// Description : Self-checking bench for io_mmio_ctrl. Captured switch values
//               are queued as expected samples and compared on each pop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_io_mmio_ctrl;

   localparam int SW_W  = 16;
   localparam int LED_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              pRead, pWrite;
   logic [1:0]        addr;
   logic [31:0]       pWriteData, pReadData;
   logic              buttonL, buttonR;
   logic [SW_W-1:0]   switch;
   logic [LED_W-1:0]  led;
`ifdef IO_IRQ_EN
   logic              irq;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb [$];
   logic [31:0] rd;

   io_mmio_ctrl #(.SW_W(SW_W), .LED_W(LED_W), .FIFO_DEP(4), .DEB_CYC(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .pRead      (pRead),
      .pWrite     (pWrite),
      .addr       (addr),
      .pWriteData (pWriteData),
      .pReadData  (pReadData),
      .buttonL    (buttonL),
      .buttonR    (buttonR),
      .switch     (switch),
`ifdef IO_IRQ_EN
      .led        (led),
      .irq        (irq)
`else
      .led        (led)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
      pRead = 1'b1;
      addr  = a;
      @(negedge clk);
      d = pReadData;
      tick(1);
      pRead = 1'b0;
      addr  = 2'd0;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      pWrite     = 1'b1;
      addr       = a;
      pWriteData = d;
      tick(1);
      pWrite     = 1'b0;
      pWriteData = '0;
      addr       = 2'd0;
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      cpu_read(2'd0, d);
      check(tag, d, exp);
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] d, e;
      e = (sb.size() != 0) ? sb.pop_front() : 32'h0;
      cpu_read(2'd1, d);
      check(tag, d, e);
   endtask

   task automatic capture(input logic [SW_W-1:0] v, input bit accept);
      switch = v;
      tick(3);
      buttonR = 1'b1;
      tick(10);
      buttonR = 1'b0;
      tick(10);
      if (accept) sb.push_back(32'(v));
   endtask

   task automatic press_l();
      buttonL = 1'b1;
      tick(10);
      buttonL = 1'b0;
      tick(10);
   endtask

   initial begin
      reset = 1'b1; pRead = 1'b0; pWrite = 1'b0; addr = 2'd0; pWriteData = '0;
      buttonL = 1'b0; buttonR = 1'b0; switch = '0;
      tick(3);
      reset = 1'b0;
      tick(1);

      // Reset state
      cpu_read(2'd0, rd); check("rst_status", rd, 32'h0);
      cpu_read(2'd1, rd); check("rst_swdata", rd, 32'h0);
      cpu_read(2'd2, rd); check("rst_ledstg", rd, 32'h0);
      check("rst_led", 32'(led), 32'h0);
`ifdef IO_IRQ_EN
      check("rst_irq", 32'(irq), 32'h0);
`endif

      // Single capture and pop
      capture(16'hA5C3, 1'b1);
      check_status("cap1_status", 32'h0000_0101);
      pop_check("cap1_pop");
      check_status("cap1_empty", 32'h0);

      // Bouncy press yields exactly one sample
      switch = 16'hBEEF;
      tick(3);
      for (int i = 0; i < 2; i++) begin
         buttonR = 1'b1; tick(2);
         buttonR = 1'b0; tick(2);
      end
      buttonR = 1'b1; tick(10);
      buttonR = 1'b0; tick(10);
      sb.push_back(32'h0000_BEEF);
      check_status("bounce_status", 32'h0000_0101);
      pop_check("bounce_pop");
      check_status("bounce_empty", 32'h0);

      // Overflow: fifth capture into a depth-4 FIFO is dropped
      for (int i = 0; i < 5; i++) capture(16'h1001 + 16'(i), i < 4);
      check_status("ovf_status", 32'h0000_040B);
      cpu_write(2'd3, 32'h1);
      check_status("ovf_cleared", 32'h0000_0403);
      for (int i = 0; i < 4; i++) pop_check("ovf_pop");
      check_status("ovf_drained", 32'h0);

      // LED stage and commit
      cpu_write(2'd2, 32'h0000_0FFF);
      cpu_read(2'd2, rd); check("stg_read", rd, 32'h0000_0FFF);
      check_status("stg_pending", 32'h0000_0004);
      press_l();
      check("led_commit", 32'(led), 32'h0000_0FFF);
      check_status("led_done", 32'h0000_0010);
      press_l();
      check("led_second", 32'(led), 32'h0000_0FFF);
      check_status("led_second_st", 32'h0000_0010);

      // Stage write in the commit cycle: old value goes out, new stays pending
      cpu_write(2'd2, 32'h0000_0123);
      buttonL = 1'b1;
      tick(6);
      pWrite = 1'b1; addr = 2'd2; pWriteData = 32'h0000_0456;
      tick(1);
      pWrite = 1'b0; addr = 2'd0; pWriteData = '0;
      tick(3);
      buttonL = 1'b0;
      tick(10);
      check("led_race", 32'(led), 32'h0000_0123);
      check_status("led_race_st", 32'h0000_0014);
      cpu_read(2'd2, rd); check("led_race_stg", rd, 32'h0000_0456);
      press_l();
      check("led_race_commit", 32'(led), 32'h0000_0456);
      cpu_write(2'd3, 32'h2);
      check_status("done_cleared", 32'h0);

      // Flush discards queued samples
      capture(16'h1111, 1'b1);
      check_status("flush_pre", 32'h0000_0101);
      cpu_write(2'd3, 32'h4);
      sb.delete();
      check_status("flush_post", 32'h0);

      // Full FIFO: pop and push in the same cycle
      for (int i = 0; i < 4; i++) capture(16'h2001 + 16'(i), 1'b1);
      check_status("full_status", 32'h0000_0403);
`ifdef IO_IRQ_EN
      check("irq_nempty", 32'(irq), 32'h1);
`endif
      switch = 16'h3333;
      tick(3);
      buttonR = 1'b1;
      tick(6);
      pRead = 1'b1; addr = 2'd1;
      @(negedge clk);
      rd = pReadData;
      tick(1);
      pRead = 1'b0; addr = 2'd0;
      check("simul_pop", rd, (sb.size() != 0) ? sb.pop_front() : 32'h0);
      sb.push_back(32'h0000_3333);
      tick(3);
      buttonR = 1'b0;
      tick(10);
      check_status("simul_status", 32'h0000_0403);
      for (int i = 0; i < 4; i++) pop_check("simul_drain");
      check_status("simul_empty", 32'h0);
`ifdef IO_IRQ_EN
      tick(2);
      check("irq_idle", 32'(irq), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
